conv_feeder: RTL and testbench

Initiator for the convolution MAC engine. Accepts a pixel stream over valid/ready and assembles a sliding window of KERNEL_SIZE pixels at stride 1. It drives the engine's start/X/KERNEL interface, holds operands until the engine's done, captures the sum, and presents it on a valid/ready output. Sits between the image line source and the conv engine in the CNN datapath.

---
 rtl/conv_feed_pkg.sv | 21 ++
 rtl/conv_window_shift.sv | 28 ++
 rtl/conv_feeder.sv | 159 +++++++++++++++
 tb/tb_conv_feeder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_feed_pkg.sv
// Shared types and defaults for the conv engine feeder: FSM states, parameter defaults, watchdog sizing.
package conv_feed_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } feed_state_t;

    localparam int CONV_INWIDTH         = 8;
    localparam int CONV_OUTWIDTH        = 25;
    localparam int CONV_KERNEL_SIZE     = 21;
    localparam int CONV_KERNEL_SIZE_BIT = 5;
    localparam int CONV_TIMEOUT         = 64;

    // The watchdog counter must be able to reach TIMEOUT itself before it fires.
    function automatic int wd_bits(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/conv_window_shift.sv
// KERNEL_SIZE-lane pixel shift register: lane 0 oldest, new pixel enters the top lane; clear wins over shift.
module conv_window_shift
    import conv_feed_pkg::*;
#(
    parameter int INWIDTH     = CONV_INWIDTH,
    parameter int KERNEL_SIZE = CONV_KERNEL_SIZE
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_shift,
    input  logic                           i_clear,
    input  logic [INWIDTH-1:0]             i_data,
    output logic [KERNEL_SIZE*INWIDTH-1:0] o_window
);

    logic [KERNEL_SIZE*INWIDTH-1:0] r_win;

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_win <= '0;
        end else if (i_shift) begin
            r_win <= {i_data, r_win[KERNEL_SIZE*INWIDTH-1:INWIDTH]};
        end
    end

    assign o_window = r_win;

endmodule

// File: rtl/conv_feeder.sv
// Feeds sliding pixel windows to the conv engine, holds operands until eng_done, returns the sum on valid/ready.
// One-cycle gap between engine starts; output backpressure stalls input. CONV_FEED_TIMEOUT_EN adds a RUN watchdog.
module conv_feeder
    import conv_feed_pkg::*;
#(
    parameter int INWIDTH         = CONV_INWIDTH,
    parameter int OUTWIDTH        = CONV_OUTWIDTH,
    parameter int KERNEL_SIZE     = CONV_KERNEL_SIZE,
    parameter int KERNEL_SIZE_BIT = CONV_KERNEL_SIZE_BIT,
    parameter int TIMEOUT         = CONV_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [INWIDTH-1:0]             in_data,
    input  logic                           in_last,
    input  logic                           kern_load,
    input  logic [KERNEL_SIZE*INWIDTH-1:0] kern_in,
    output logic                           eng_start,
    output logic [KERNEL_SIZE*INWIDTH-1:0] eng_x,
    output logic [KERNEL_SIZE*INWIDTH-1:0] eng_kernel,
    input  logic [OUTWIDTH-1:0]            eng_result,
    input  logic                           eng_done,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUTWIDTH-1:0]            out_data,
    output logic                           out_err
);

    localparam int VW = KERNEL_SIZE * INWIDTH;
    localparam logic [KERNEL_SIZE_BIT-1:0] K_FULL  = KERNEL_SIZE_BIT'(KERNEL_SIZE);
    localparam logic [KERNEL_SIZE_BIT-1:0] K_SLIDE = KERNEL_SIZE_BIT'(KERNEL_SIZE - 1);

    feed_state_t                r_state;
    logic [KERNEL_SIZE_BIT-1:0] r_count;
    logic                       r_last;
    logic                       r_eng_start;
    logic                       r_out_valid;
    logic [VW-1:0]              r_kernel;
    logic [OUTWIDTH-1:0]        r_out_data;

    logic                       w_accept;
    logic                       w_full;
    logic                       w_clear;
    logic [KERNEL_SIZE_BIT-1:0] w_count_nxt;

    assign w_accept    = in_valid && (r_state == FILL);
    assign w_count_nxt = (r_count == K_FULL) ? K_FULL : r_count + 1'b1;
    assign w_full      = (w_count_nxt == K_FULL);
    // A finished line restarts from an empty window; otherwise the window keeps K-1 pixels to slide.
    assign w_clear     = (r_state == OUT) && out_ready && r_last;

    conv_window_shift #(
        .INWIDTH    (INWIDTH),
        .KERNEL_SIZE(KERNEL_SIZE)
    ) u_window (
        .clk     (clk),
        .reset   (reset),
        .i_shift (w_accept),
        .i_clear (w_clear),
        .i_data  (in_data),
        .o_window(eng_x)
    );

`ifdef CONV_FEED_TIMEOUT_EN
    localparam int WD_W = wd_bits(TIMEOUT);
    logic [WD_W-1:0] r_wd;
    logic            r_out_err;
    assign out_err = r_out_err;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^TIMEOUT;
    assign out_err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= FILL;
            r_count     <= '0;
            r_last      <= 1'b0;
            r_kernel    <= '0;
            r_eng_start <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
`ifdef CONV_FEED_TIMEOUT_EN
            r_wd        <= '0;
            r_out_err   <= 1'b0;
`endif
        end else begin
            if (kern_load && (r_state != RUN)) begin
                r_kernel <= kern_in;
            end
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (w_full) begin
                            r_count     <= w_count_nxt;
                            r_last      <= in_last;
                            r_eng_start <= 1'b1;
                            r_state     <= RUN;
                        end else if (in_last) begin
                            r_count <= '0;
                            r_last  <= 1'b0;
                        end else begin
                            r_count <= w_count_nxt;
                            r_last  <= in_last;
                        end
                    end
                end
                RUN: begin
                    if (eng_done) begin
                        r_out_data  <= eng_result;
                        r_eng_start <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
`ifdef CONV_FEED_TIMEOUT_EN
                        r_out_err   <= 1'b0;
                        r_wd        <= '0;
`endif
                    end
`ifdef CONV_FEED_TIMEOUT_EN
                    else if (r_wd == WD_W'(TIMEOUT)) begin
                        r_out_data  <= '0;
                        r_out_err   <= 1'b1;
                        r_eng_start <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_wd        <= '0;
                        r_state     <= OUT;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
`endif
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= FILL;
                        if (r_last) begin
                            r_count <= '0;
                            r_last  <= 1'b0;
                        end else begin
                            r_count <= K_SLIDE;
                        end
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign in_ready   = (r_state == FILL);
    // Gated by reset so the engine sees start fall while reset is still asserted.
    assign eng_start  = r_eng_start & reset;
    assign eng_kernel = r_kernel;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;

endmodule

// File: tb/tb_conv_feeder.sv
// Bench for conv_feeder with K=3, 8-bit pixels and a mock engine answering sum(x*k) three cycles after start.
module tb_conv_feeder;

    localparam int W  = 8;
    localparam int OW = 25;
    localparam int K  = 3;
    localparam int KB = 2;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid, in_ready, in_last, kern_load;
    logic [W-1:0]   in_data;
    logic [K*W-1:0] kern_in, eng_x, eng_kernel;
    logic           eng_start, eng_done, out_valid, out_ready, out_err;
    logic [OW-1:0]  eng_result, out_data;

    always #5 clk = ~clk;

    conv_feeder #(
        .INWIDTH(W), .OUTWIDTH(OW), .KERNEL_SIZE(K), .KERNEL_SIZE_BIT(KB), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .kern_load(kern_load), .kern_in(kern_in),
        .eng_start(eng_start), .eng_x(eng_x), .eng_kernel(eng_kernel),
        .eng_result(eng_result), .eng_done(eng_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // Mock engine
    int eng_cnt = 0;
    bit eng_never = 1'b0;
    always @(posedge clk) begin
        if (!eng_start) eng_cnt <= 0;
        else            eng_cnt <= eng_cnt + 1;
    end
    assign eng_done = eng_start && (eng_cnt == 2) && !eng_never;
    always_comb begin
        eng_result = '0;
        for (int i = 0; i < K; i++)
            eng_result += OW'(eng_x[i*W +: W]) * OW'(eng_kernel[i*W +: W]);
    end

    // Model: pixels of the current line; every K consecutive pixels of one line make one window.
    logic [K*W-1:0] m_kernel;
    logic [W-1:0]   m_line[$];
    logic [K*W-1:0] exp_x[$];
    logic [OW-1:0]  exp_sum[$];
    logic           exp_err[$];
    logic [OW-1:0]  out_log[$];
    bit             wd_mode = 1'b0;

    task automatic model_accept(input logic [W-1:0] d, input logic last);
        logic [K*W-1:0] win;
        logic [OW-1:0]  sum;
        m_line.push_back(d);
        if (m_line.size() >= K) begin
            sum = '0;
            for (int i = 0; i < K; i++) begin
                win[i*W +: W] = m_line[m_line.size() - K + i];
                sum += OW'(win[i*W +: W]) * OW'(m_kernel[i*W +: W]);
            end
            exp_x.push_back(win);
            exp_sum.push_back(wd_mode ? '0 : sum);
            exp_err.push_back(wd_mode);
        end
        if (last) m_line.delete();
    endtask

    // Compare process
    logic           prev_start = 1'b0, prev_ov = 1'b0;
    logic [K*W-1:0] held_x, held_k;
    int             t_start = 0, t_ov = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (eng_start && !prev_start) begin
                t_start = cyc;
                chk("start_expected", 64'(exp_x.size() != 0), 1);
                if (exp_x.size() != 0) begin
                    chk("eng_x", eng_x, exp_x.pop_front());
                    chk("eng_kernel", eng_kernel, m_kernel);
                end
                held_x = eng_x;
                held_k = eng_kernel;
            end else if (eng_start) begin
                chk("eng_x_frozen", eng_x, held_x);
                chk("eng_kernel_frozen", eng_kernel, held_k);
            end
            if (out_valid && !prev_ov) t_ov = cyc;
            if (out_valid) begin
                chk("start_low_in_out", eng_start, 0);
                chk("in_ready_low_in_out", in_ready, 0);
            end
            if (out_valid && out_ready) begin
                chk("output_expected", 64'(exp_sum.size() != 0), 1);
                if (exp_sum.size() != 0) begin
                    chk("out_data", out_data, exp_sum.pop_front());
                    chk("out_err", out_err, exp_err.pop_front());
                end
                out_log.push_back(out_data);
            end
            prev_start = eng_start;
            prev_ov    = out_valid;
        end else begin
            prev_start = 1'b0;
            prev_ov    = 1'b0;
        end
    end

    function automatic logic [K*W-1:0] kvec(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        return {c, b, a};
    endfunction

    task automatic send_pixel(input logic [W-1:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("in_ready_timeout", in_ready, 1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(d, last);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic load_kernel(input logic [K*W-1:0] k, input bit taken);
        kern_load = 1'b1;
        kern_in   = k;
        @(negedge clk);
        kern_load = 1'b0;
        if (taken) m_kernel = k;
        chk("kernel_reg", eng_kernel, m_kernel);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_sum.size() == 0 && !out_valid && in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("drain_timeout", exp_sum.size(), 0);
    endtask

    initial begin
        logic [OW-1:0] lit[$];
        lit = '{6, 9, 18, 33, 6, 15, 5, 3};
        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        kern_load = 1'b0; kern_in = '0; out_ready = 1'b1; m_kernel = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_eng_x", eng_x, 0);
        chk("rst_eng_kernel", eng_kernel, 0);
        reset = 1'b1;
        @(negedge clk);

        // Window and slide
        load_kernel(kvec(1, 1, 1), 1);
        send_pixel(1, 0); send_pixel(2, 0); send_pixel(3, 0); send_pixel(4, 1);
        wait_idle();

        // Line end, then a partial line that must be dropped
        send_pixel(5, 0); send_pixel(6, 0); send_pixel(7, 1);
        wait_idle();
        send_pixel(8, 0); send_pixel(9, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("partial_no_start", eng_start, 0);
            chk("partial_no_valid", out_valid, 0);
        end
        send_pixel(10, 0); send_pixel(11, 0); send_pixel(12, 1);
        wait_idle();

        // Backpressure
        out_ready = 1'b0;
        send_pixel(1, 0); send_pixel(2, 0); send_pixel(3, 1);
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        chk("bp_out_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_data", out_data, 6);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_eng_start", eng_start, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_idle();

        // Kernel load ignored in RUN, honoured in FILL
        send_pixel(4, 0); send_pixel(5, 0); send_pixel(6, 1);
        chk("run_entered", eng_start, 1);
        load_kernel(kvec(2, 0, 1), 0);
        wait_idle();
        load_kernel(kvec(2, 0, 1), 1);
        send_pixel(1, 0); send_pixel(2, 0); send_pixel(3, 1);
        wait_idle();

        // Reset while the engine is running
        send_pixel(7, 0); send_pixel(8, 0); send_pixel(9, 1);
        chk("pre_reset_start", eng_start, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_x.delete(); exp_sum.delete(); exp_err.delete(); m_line.delete();
        m_kernel = '0;
        chk("post_reset_start", eng_start, 0);
        chk("post_reset_valid", out_valid, 0);
        chk("post_reset_in_ready", in_ready, 1);
        chk("post_reset_kernel", eng_kernel, 0);
        load_kernel(kvec(1, 1, 1), 1);
        send_pixel(1, 0); send_pixel(1, 0); send_pixel(1, 1);
        wait_idle();

`ifdef CONV_FEED_TIMEOUT_EN
        wd_mode = 1'b1;
        eng_never = 1'b1;
        send_pixel(2, 0); send_pixel(3, 0); send_pixel(4, 1);
        wait_idle();
        chk("wd_latency", 64'(t_ov - t_start), 9);
        wd_mode = 1'b0;
        eng_never = 1'b0;
        lit.push_back(0);
`endif

        chk("output_count", out_log.size(), lit.size());
        for (int i = 0; i < lit.size() && i < out_log.size(); i++)
            chk("literal_sum", out_log[i], lit[i]);
        chk("leftover_windows", exp_x.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
